div_datapath: RTL

Register-and-arithmetic half of the iterative non-restoring divider. Sits directly downstream of the divider control FSM: it executes that FSM's per-cycle commands (`add`, `sub`, `shiftQuotient`, `nop`, `ready`) on the remainder/quotient registers. It returns the remainder sign (`MSB`) and the quotient LSB (`Q0`) to the FSM as status, and it produces the final signed quotient, remainder and exception flag for the multdiv result mux.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_datapath_addsub.sv | 26 ++
 rtl/div_datapath.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative non-restoring divider datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_pkg;

   localparam int DIV_WIDTH = 32;

   // Listed from highest to lowest priority. When several commands are
   // asserted in one cycle, the decoder picks the first one in this list.
   typedef enum logic [2:0] {
      CMD_LOAD,
      CMD_READY,
      CMD_SHIFT,
      CMD_SUB,
      CMD_ADD,
      CMD_NOP
   } div_cmd_e;

   // Magnitude of a two's complement value, read back as unsigned.
   // The most negative input maps onto itself, which is the correct
   // unsigned magnitude 2^(DIV_WIDTH-1).
   function automatic logic [DIV_WIDTH-1:0] abs_u(input logic [DIV_WIDTH-1:0] x);
      return x[DIV_WIDTH-1] ? -x : x;
   endfunction

endpackage

// File: rtl/div_datapath_addsub.sv
// N-bit adder/subtractor shared by the add, sub and remainder-correction steps.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a_dat/b_dat operands, sub_en selects a-b (else a+b), sum_dat result.
// The carry out of the top bit is discarded.
module addsub_n #(
   parameter int N = 33
) (
   input  logic [N-1:0] a_dat,
   input  logic [N-1:0] b_dat,
   input  logic         sub_en,
   output logic [N-1:0] sum_dat
);

   logic [N-1:0] b_eff;
   logic [N-1:0] cin;

   always_comb begin
      b_eff = sub_en ? ~b_dat : b_dat;
      cin   = {{(N-1){1'b0}}, sub_en};
   end

   // Subtraction as a + ~b + 1, which keeps a single carry chain.
   assign sum_dat = a_dat + b_eff + cin;

endmodule

// File: rtl/div_datapath.sv
// Register/arithmetic half of the non-restoring divider; runs one FSM command per cycle.
// Latency: one clock per command; data_resultRDY rises on the edge after ready is sampled.
// Backpressure: none; the FSM paces the datapath and the result pulse cannot be stalled.
// Ports:
//   clock, reset_n          : clock and synchronous active-low reset
//   load, operandA/B        : start a new division with signed operands
//   shiftQuotient/sub/add/nop/ready : per-cycle commands from the divider FSM
//   MSB, Q0                 : remainder sign and quotient LSB back to the FSM
//   data_result/remainder/exception/resultRDY : finished signed result
module div_datapath
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic             shiftQuotient,
   input  logic             sub,
   input  logic             add,
   input  logic             nop,
   input  logic             ready,
   output logic             MSB,
   output logic             Q0,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_cmd_e         cmd;

   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH:0]   d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             exc_q, exc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             exception_q, exception_d;
   logic             rdy_q, rdy_d;

   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] rc_lo;
   logic             load_exc;

   // Operand magnitudes: the package helper covers the default width, other
   // widths fall back to the same expression sized locally.
   if (WIDTH == DIV_WIDTH) begin : g_abs_pkg
      assign a_abs = abs_u(operandA);
      assign b_abs = abs_u(operandB);
   end else begin : g_abs_local
      assign a_abs = operandA[WIDTH-1] ? -operandA : operandA;
      assign b_abs = operandB[WIDTH-1] ? -operandB : operandB;
   end

   // Divide by zero, or the one signed quotient that does not fit (MIN / -1).
   assign load_exc = (operandB == '0) | ((operandA == MIN_NEG) & (operandB == '1));

   // Command priority encoder.
   always_comb begin
      cmd = CMD_NOP;
      if (load)               cmd = CMD_LOAD;
      else if (ready)         cmd = CMD_READY;
      else if (shiftQuotient) cmd = CMD_SHIFT;
      else if (sub)           cmd = CMD_SUB;
      else if (add)           cmd = CMD_ADD;
      else if (nop)           cmd = CMD_NOP;
   end

   // One adder serves sub, add and the final correction (R + D, add mode).
   addsub_n #(
      .N (WIDTH + 1)
   ) u_addsub (
      .a_dat   (r_q),
      .b_dat   (d_q),
      .sub_en  (cmd == CMD_SUB),
      .sum_dat (sum)
   );

   // A negative final partial remainder is restored by adding D back once.
   assign rc_lo = r_q[WIDTH] ? sum[WIDTH-1:0] : r_q[WIDTH-1:0];

   always_comb begin
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      exc_d       = exc_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      exception_d = exception_q;
      rdy_d       = 1'b0;

      case (cmd)
         CMD_LOAD: begin
            q_d   = a_abs;
            d_d   = {1'b0, b_abs};
            r_d   = '0;
            sa_d  = operandA[WIDTH-1];
            sb_d  = operandB[WIDTH-1];
            exc_d = load_exc;
         end
         CMD_READY: begin
            result_d    = exc_q ? '0 : ((sa_q ^ sb_q) ? -q_q : q_q);
            remainder_d = exc_q ? '0 : (sa_q ? -rc_lo : rc_lo);
            exception_d = exc_q;
            rdy_d       = 1'b1;
         end
         CMD_SHIFT: begin
            // The old sign bit of R falls off the top; Q[0] fills with 0.
            {r_d, q_d} = {r_q[WIDTH-1:0], q_q, 1'b0};
         end
         CMD_SUB, CMD_ADD: begin
            r_d = sum;
            q_d = {q_q[WIDTH-1:1], ~sum[WIDTH]};
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         exc_q       <= 1'b0;
         result_q    <= '0;
         remainder_q <= '0;
         exception_q <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         exc_q       <= exc_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         exception_q <= exception_d;
         rdy_q       <= rdy_d;
      end
   end

   assign MSB            = r_q[WIDTH];
   assign Q0             = q_q[0];
   assign data_result    = result_q;
   assign data_remainder = remainder_q;
   assign data_exception = exception_q;
   assign data_resultRDY = rdy_q;

endmodule
